// File: rtl/csr_hpm_if.sv
// CSR access port shared by the main CSR block and the performance-monitor bank.
// The master drives address/op/operand; the slave returns hit, error and read data.
interface csr_hpm_if;
  logic [11:0] mem1_csr_addr;
  logic [1:0]  mem1_csr_write;
  logic [31:0] mem1_csr_din;
  logic        hpm_hit;
  logic        hpm_error;
  logic [31:0] hpm_dout;

  modport master (
    output mem1_csr_addr, mem1_csr_write, mem1_csr_din,
    input  hpm_hit, hpm_error, hpm_dout
  );

  modport slave (
    input  mem1_csr_addr, mem1_csr_write, mem1_csr_din,
    output hpm_hit, hpm_error, hpm_dout
  );
endinterface

// File: rtl/csr_hpm.sv
// Machine-mode cycle/instret and event-selectable performance counters with
// counter-inhibit, sticky per-counter overflow flags and a registered overflow IRQ.
module csr_hpm #(
  parameter int NUM_CTRS   = 4,
  parameter int CTR_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk_core,
  input  logic                  reset,
  csr_hpm_if.slave              csr,
  input  logic                  wb_valid,
  input  logic [NUM_EVENTS-1:0] hpm_event,
  output logic                  hpm_ovf_irq
);
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_CTRS) - 32'h1) << 3);

  typedef logic [CTR_WIDTH-1:0] ctr_t;

  ctr_t                r_cycle, r_instret;
  ctr_t                r_hpm [NUM_CTRS];
  logic [7:0]          r_sel [NUM_CTRS];
  logic [NUM_CTRS-1:0] r_inten, r_of;
  logic [31:0]         r_inhibit;
  logic                r_irq;

  logic [11:0]         w_addr, w_evt_idx;
  logic [4:0]          w_ctr_n;
  logic                w_is_inh, w_is_evt, w_is_ctr, w_is_shadow, w_ctr_hi;
  logic                w_hit, w_wr, w_err, w_we, w_wr_lo, w_wr_hi;
  logic [31:0]         w_dout, w_wdata;
  logic [7:0]          w_sel_legal;
  ctr_t                w_ctr_rd, w_cycle_nxt, w_instret_nxt;
  ctr_t                w_hpm_nxt [NUM_CTRS];
  logic [7:0]          w_sel_nxt [NUM_CTRS];
  logic [63:0]         w_rd64;
  logic [255:0]        w_event_ext;
  logic [NUM_CTRS-1:0] w_hpm_inc, w_hpm_wr, w_evt_wr, w_of_nxt, w_inten_nxt;

  // Low-half writes keep the upper bits and vice versa; any write cancels the increment.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic wr_lo, input logic wr_hi,
                                    input logic inc, input logic [31:0] wd);
    logic [63:0] v;
    v = '0;
    v[CTR_WIDTH-1:0] = cur;
    if (wr_lo)      v[31:0]  = wd;
    else if (wr_hi) v[63:32] = wd;
    else if (inc)   v        = v + 64'd1;
    return v[CTR_WIDTH-1:0];
  endfunction

  assign w_addr = csr.mem1_csr_addr;

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_is_inh    = (w_addr == 12'h320);
    w_is_evt    = (w_addr >= 12'h323) && (w_addr <= 12'h33F);
    w_evt_idx   = w_addr - 12'h323;
    w_is_shadow = (w_addr[11:8] == 4'hC);
    w_is_ctr    = ((w_addr[11:8] == 4'hB) || w_is_shadow) && (w_addr[6:5] == 2'b00)
                  && (w_addr[4:0] != 5'd1);
    w_ctr_n     = w_addr[4:0];
    w_ctr_hi    = w_addr[7];
    w_hit       = w_is_inh || w_is_evt || w_is_ctr;
    w_wr        = (csr.mem1_csr_write != 2'b00);
    w_err       = w_hit && w_wr && w_is_shadow;
    w_we        = w_hit && w_wr && !w_is_shadow;
    w_wr_lo     = w_we && w_is_ctr && !w_ctr_hi;
    w_wr_hi     = w_we && w_is_ctr && w_ctr_hi;

    w_ctr_rd = '0;
    if (w_ctr_n == 5'd0) w_ctr_rd = r_cycle;
    if (w_ctr_n == 5'd2) w_ctr_rd = r_instret;
    for (int i = 0; i < NUM_CTRS; i++)
      if (w_ctr_n == 5'(i + 3)) w_ctr_rd = r_hpm[i];
    w_rd64 = '0;
    w_rd64[CTR_WIDTH-1:0] = w_ctr_rd;

    w_dout = '0;
    if (w_is_inh) begin
      w_dout = r_inhibit;
    end else if (w_is_evt) begin
      for (int i = 0; i < NUM_CTRS; i++)
        if (w_evt_idx == 12'(i)) w_dout = {r_of[i], r_inten[i], 22'd0, r_sel[i]};
    end else if (w_is_ctr) begin
      w_dout = w_ctr_hi ? w_rd64[63:32] : w_rd64[31:0];
    end

    case (csr.mem1_csr_write)
      2'b10:   w_wdata = w_dout | csr.mem1_csr_din;
      2'b11:   w_wdata = w_dout & ~csr.mem1_csr_din;
      default: w_wdata = csr.mem1_csr_din;
    endcase
    w_sel_legal = ({1'b0, w_wdata[7:0]} < 9'(NUM_EVENTS)) ? w_wdata[7:0] : 8'd0;
  end

  always_comb begin
    w_event_ext = '0;
    w_event_ext[NUM_EVENTS-1:0] = hpm_event;
    w_event_ext[0] = 1'b0;

    w_cycle_nxt   = ctr_next(r_cycle, w_wr_lo && (w_ctr_n == 5'd0), w_wr_hi && (w_ctr_n == 5'd0),
                             !r_inhibit[0], w_wdata);
    w_instret_nxt = ctr_next(r_instret, w_wr_lo && (w_ctr_n == 5'd2), w_wr_hi && (w_ctr_n == 5'd2),
                             wb_valid && !r_inhibit[2], w_wdata);

    for (int i = 0; i < NUM_CTRS; i++) begin
      w_hpm_inc[i]   = (r_sel[i] != 8'd0) && w_event_ext[r_sel[i]] && !r_inhibit[3+i];
      w_hpm_wr[i]    = w_we && w_is_ctr && (w_ctr_n == 5'(i + 3));
      w_hpm_nxt[i]   = ctr_next(r_hpm[i], w_hpm_wr[i] && !w_ctr_hi, w_hpm_wr[i] && w_ctr_hi,
                                w_hpm_inc[i], w_wdata);
      w_evt_wr[i]    = w_we && w_is_evt && (w_evt_idx == 12'(i));
      // A hardware wrap in the same cycle as a software write of OF always leaves OF set.
      w_of_nxt[i]    = (w_hpm_inc[i] && !w_hpm_wr[i] && (&r_hpm[i]))
                       | (w_evt_wr[i] ? w_wdata[31] : r_of[i]);
      w_inten_nxt[i] = w_evt_wr[i] ? w_wdata[30] : r_inten[i];
      w_sel_nxt[i]   = w_evt_wr[i] ? w_sel_legal : r_sel[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_cycle   <= '0;
      r_instret <= '0;
      r_inhibit <= '0;
      r_inten   <= '0;
      r_of      <= '0;
      r_irq     <= 1'b0;
      // NOTE: these arrays are a handful of flops, not RAM, so resetting them is cheap and required.
      for (int i = 0; i < NUM_CTRS; i++) begin
        r_hpm[i] <= '0;
        r_sel[i] <= '0;
      end
    end else begin
      r_cycle   <= w_cycle_nxt;
      r_instret <= w_instret_nxt;
      if (w_we && w_is_inh) r_inhibit <= w_wdata & INH_MASK;
      r_inten   <= w_inten_nxt;
      r_of      <= w_of_nxt;
      r_irq     <= |(r_of & r_inten);
      for (int i = 0; i < NUM_CTRS; i++) begin
        r_hpm[i] <= w_hpm_nxt[i];
        r_sel[i] <= w_sel_nxt[i];
      end
    end
  end

  assign csr.hpm_hit   = w_hit;
  assign csr.hpm_error = w_err;
  assign csr.hpm_dout  = w_dout;
  assign hpm_ovf_irq   = r_irq;
endmodule

// File: tb/tb_csr_hpm.sv
// Directed self-checking bench for csr_hpm (NUM_CTRS=4, CTR_WIDTH=64, NUM_EVENTS=8).
// Inputs change on the falling edge; outputs are sampled just after it.
module tb_csr_hpm;
  logic       clk_core = 1'b0;
  logic       reset;
  logic       wb_valid;
  logic [7:0] hpm_event;
  logic       hpm_ovf_irq;

  csr_hpm_if bus ();

  csr_hpm #(.NUM_CTRS(4), .CTR_WIDTH(64), .NUM_EVENTS(8)) dut (
    .clk_core    (clk_core),
    .reset       (reset),
    .csr         (bus.slave),
    .wb_valid    (wb_valid),
    .hpm_event   (hpm_event),
    .hpm_ovf_irq (hpm_ovf_irq)
  );

  always #50 clk_core = ~clk_core;

  int n_checks = 0;
  int n_errors = 0;

  // Reference for cycle/instret, tracking only software writes of mcountinhibit.
  logic [63:0] m_cycle, m_instret;
  logic [31:0] m_inh;
  always @(posedge clk_core) begin
    if (reset) begin
      m_cycle   <= '0;
      m_instret <= '0;
      m_inh     <= '0;
    end else begin
      if (!m_inh[0]) m_cycle <= m_cycle + 64'd1;
      if (wb_valid && !m_inh[2]) m_instret <= m_instret + 64'd1;
      if (bus.mem1_csr_write == 2'b01 && bus.mem1_csr_addr == 12'h320) m_inh <= bus.mem1_csr_din;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic csr_op(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d,
                        input logic [7:0] ev);
    bus.mem1_csr_addr  = a;
    bus.mem1_csr_write = op;
    bus.mem1_csr_din   = d;
    hpm_event          = ev;
    @(negedge clk_core);
    bus.mem1_csr_write = 2'b00;
    hpm_event          = '0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_op(a, 2'b01, d, 8'h00);
  endtask

  task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.mem1_csr_addr = a;
    #1;
    check(tag, bus.hpm_dout, exp);
  endtask

  task automatic pulse(input logic [7:0] ev, input int n);
    hpm_event = ev;
    repeat (n) @(negedge clk_core);
    hpm_event = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    wb_valid = 1'b0;
    hpm_event = '0;
    bus.mem1_csr_addr = '0;
    bus.mem1_csr_write = 2'b00;
    bus.mem1_csr_din = '0;
    repeat (3) @(negedge clk_core);
    reset = 1'b0;

    // Reset state and free-running cycle counter
    check("irq_rst", hpm_ovf_irq, 1'b0);
    chk_rd("mcycle_rst", 12'hB00, 32'd0);
    repeat (10) @(negedge clk_core);
    chk_rd("mcycle_10", 12'hB00, 32'd10);
    check("hit_b00", bus.hpm_hit, 1'b1);
    chk_rd("mcycleh_0", 12'hB80, 32'd0);
    chk_rd("cycle_shadow", 12'hC00, 32'd10);
    chk_rd("minstret_rst", 12'hB02, 32'd0);
    chk_rd("inhibit_rst", 12'h320, 32'd0);
    chk_rd("evt3_rst", 12'h323, 32'd0);

    // Overflow flag and interrupt
    csr_wr(12'h323, 32'hC000_0002);
    chk_rd("evt3_wr", 12'h323, 32'hC000_0002);
    csr_op(12'h323, 2'b11, 32'h8000_0000, 8'h00);
    chk_rd("evt3_clr_of", 12'h323, 32'h4000_0002);
    csr_wr(12'hB03, 32'hFFFF_FFFE);
    csr_wr(12'hB83, 32'hFFFF_FFFF);
    chk_rd("hpm3_lo_wr", 12'hB03, 32'hFFFF_FFFE);
    chk_rd("hpm3_hi_wr", 12'hB83, 32'hFFFF_FFFF);
    check("irq_pre", hpm_ovf_irq, 1'b0);
    pulse(8'h04, 1);
    chk_rd("hpm3_max", 12'hB03, 32'hFFFF_FFFF);
    pulse(8'h04, 1);
    chk_rd("hpm3_wrap_lo", 12'hB03, 32'd0);
    chk_rd("hpm3_wrap_hi", 12'hB83, 32'd0);
    chk_rd("of_set", 12'h323, 32'hC000_0002);
    check("irq_lag", hpm_ovf_irq, 1'b0);
    @(negedge clk_core);
    check("irq_set", hpm_ovf_irq, 1'b1);
    csr_op(12'h323, 2'b11, 32'h8000_0000, 8'h00);
    chk_rd("of_cleared", 12'h323, 32'h4000_0002);
    @(negedge clk_core);
    check("irq_drop", hpm_ovf_irq, 1'b0);

    // Counter inhibit
    csr_wr(12'h320, 32'h5);
    chk_rd("inhibit_rd", 12'h320, 32'h5);
    wb_valid = 1'b1;
    repeat (20) @(negedge clk_core);
    chk_rd("cycle_frozen", 12'hB00, m_cycle[31:0]);
    chk_rd("instret_frozen", 12'hB02, 32'd0);
    csr_wr(12'h320, 32'hFFFF_FFFF);
    chk_rd("inhibit_mask", 12'h320, 32'h7D);
    csr_wr(12'h320, 32'h0);
    repeat (5) @(negedge clk_core);
    chk_rd("cycle_resume", 12'hB00, m_cycle[31:0]);
    chk_rd("instret_resume", 12'hB02, 32'd5);
    wb_valid = 1'b0;

    // Event selector legality
    csr_wr(12'h323, 32'h0000_00C8);
    chk_rd("sel200", 12'h323, 32'd0);
    csr_wr(12'h323, 32'h0000_0008);
    chk_rd("sel8", 12'h323, 32'd0);
    pulse(8'hFF, 3);
    chk_rd("sel0_nocount", 12'hB03, 32'd0);
    csr_wr(12'h323, 32'h0000_0007);
    chk_rd("sel7", 12'h323, 32'd7);
    pulse(8'h80, 3);
    chk_rd("sel7_count", 12'hB03, 32'd3);

    // Read-only shadows and unimplemented windows
    bus.mem1_csr_addr = 12'hC02; bus.mem1_csr_write = 2'b01; bus.mem1_csr_din = 32'h1234;
    #1;
    check("err_c02", bus.hpm_error, 1'b1);
    check("hit_c02", bus.hpm_hit, 1'b1);
    @(negedge clk_core);
    bus.mem1_csr_write = 2'b00;
    chk_rd("instret_kept", 12'hB02, m_instret[31:0]);
    bus.mem1_csr_addr = 12'hC80; bus.mem1_csr_write = 2'b11;
    #1;
    check("err_c80_clr", bus.hpm_error, 1'b1);
    @(negedge clk_core);
    bus.mem1_csr_write = 2'b00;
    chk_rd("b1f_zero", 12'hB1F, 32'd0);
    check("hit_b1f", bus.hpm_hit, 1'b1);
    bus.mem1_csr_write = 2'b01; bus.mem1_csr_din = 32'hFFFF;
    #1;
    check("err_b1f_wr", bus.hpm_error, 1'b0);
    @(negedge clk_core);
    bus.mem1_csr_write = 2'b00;
    chk_rd("b01_zero", 12'hB01, 32'd0);
    check("hit_b01", bus.hpm_hit, 1'b0);
    chk_rd("evt_unimpl", 12'h327, 32'd0);
    check("hit_327", bus.hpm_hit, 1'b1);

    // Same-cycle write versus increment
    csr_op(12'hB03, 2'b01, 32'd5, 8'h80);
    chk_rd("wr_beats_inc", 12'hB03, 32'd5);
    csr_op(12'hB83, 2'b01, 32'd0, 8'h80);
    chk_rd("hiwr_cancels_inc", 12'hB03, 32'd5);
    csr_wr(12'hB83, 32'hA5);
    csr_wr(12'hB03, 32'd1);
    chk_rd("lo_keeps_hi", 12'hB83, 32'hA5);
    chk_rd("lo_written", 12'hB03, 32'd1);
    csr_wr(12'hB03, 32'hFFFF_FFFF);
    csr_wr(12'hB83, 32'hFFFF_FFFF);
    csr_op(12'h323, 2'b01, 32'h0000_0007, 8'h80);
    chk_rd("hw_of_wins", 12'h323, 32'h8000_0007);
    chk_rd("race_wrap", 12'hB03, 32'd0);
    check("irq_no_inten", hpm_ovf_irq, 1'b0);
    csr_op(12'h323, 2'b10, 32'h4000_0000, 8'h00);
    check("irq_inten_lag", hpm_ovf_irq, 1'b0);
    @(negedge clk_core);
    check("irq_inten", hpm_ovf_irq, 1'b1);

    // Reset mid-count with events and retirement active
    wb_valid = 1'b1;
    hpm_event = 8'h80;
    reset = 1'b1;
    @(negedge clk_core);
    reset = 1'b0;
    hpm_event = '0;
    wb_valid = 1'b0;
    check("irq_midrst", hpm_ovf_irq, 1'b0);
    chk_rd("cycle_midrst", 12'hB00, 32'd0);
    chk_rd("cycleh_midrst", 12'hB80, 32'd0);
    chk_rd("instret_midrst", 12'hB02, 32'd0);
    chk_rd("hpm3_midrst", 12'hB03, 32'd0);
    chk_rd("hpm3h_midrst", 12'hB83, 32'd0);
    chk_rd("evt3_midrst", 12'h323, 32'd0);
    chk_rd("inhibit_midrst", 12'h320, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
